// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, response causes,
// FSM states and the request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Stores only have byte/half/word; loads add the unsigned byte/half forms.
  function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
    logic ok;
    if (write) ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else       ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

  // Access size lives in funct3[1:0] for every legal encoding; bytes never misalign.
  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data formatting: picks the addressed byte/halfword lane out of the bus
// word and sign- or zero-extends it to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Lane select followed by extension chosen by funct3.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    lane_byte = rd_data[7:0];
    lane_half = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    result    = 32'h0;
    case (addr_lo)
      2'd0:    lane_byte = rd_data[7:0];
      2'd1:    lane_byte = rd_data[15:8];
      2'd2:    lane_byte = rd_data[23:16];
      default: lane_byte = rd_data[31:24];
    endcase
    case (funct3)
      F3_B:    result = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    result = {{16{lane_half[15]}}, lane_half};
      F3_W:    result = rd_data;
      F3_BU:   result = {24'h0, lane_byte};
      F3_HU:   result = {16'h0, lane_half};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Memory-stage load/store unit: one request at a time, one pipelined Wishbone
// cycle per legal request, one registered response per request. Misaligned
// and illegal requests are answered without touching the bus; a slave that
// never acks is abandoned after TIMEOUT_CYCLES cycles in WAIT.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [1:0]            resp_cause,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_wr_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [31:0]           wb_wr_data,
  output logic [3:0]            wb_wr_sel,
  input  logic                  wb_ack,
  input  logic                  wb_stall,
  input  logic [31:0]           wb_rd_data
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [1:0]       addr_lo_q;
  logic [2:0]       funct3_q;
  logic             write_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_d;
  logic [31:0]      rdata_d;
  logic             accept;
  logic             req_illegal;
  logic             req_misaligned;
  logic [3:0]       fmt_sel;
  logic [31:0]      fmt_data;
  logic [31:0]      load_result;
  logic             unused_addr_hi;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign accept         = req_valid && req_ready;
  assign req_illegal    = !funct3_legal(req_write, req_funct3);
  assign req_misaligned = !req_illegal && addr_misaligned(req_funct3, req_addr[1:0]);

  lsu_load_extend u_load_extend (
    .rd_data (wb_rd_data),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  // Store lane replication and byte selects; loads read the whole word.
  always_comb begin
    fmt_sel  = 4'b1111;
    fmt_data = 32'h0;
    if (req_write) begin
      case (req_funct3)
        F3_B: begin
          fmt_sel  = 4'b0001 << req_addr[1:0];
          fmt_data = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          fmt_sel  = 4'b0011 << req_addr[1:0];
          fmt_data = {2{req_wdata[15:0]}};
        end
        default: begin
          fmt_sel  = 4'b1111;
          fmt_data = req_wdata;
        end
      endcase
    end
  end

  // Next state plus the response payload to register when entering RESP.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cause_d = CAUSE_NONE;
    rdata_d = 32'h0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept) begin
          if (req_illegal) begin
            state_d = ST_RESP;
            cause_d = CAUSE_ILLEGAL;
          end else if (req_misaligned) begin
            state_d = ST_RESP;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (!wb_stall) begin
          if (wb_ack) begin
            state_d = ST_RESP;
            rdata_d = write_q ? 32'h0 : load_result;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wb_ack) begin
          state_d = ST_RESP;
          rdata_d = write_q ? 32'h0 : load_result;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RESP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered control/response outputs derived from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      req_ready  <= 1'b1;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_cause <= CAUSE_NONE;
      resp_rdata <= 32'h0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      req_ready  <= (state_d == ST_IDLE);
      wb_cyc     <= (state_d == ST_REQ) || (state_d == ST_WAIT);
      wb_stb     <= (state_d == ST_REQ);
      resp_valid <= (state_d == ST_RESP);
      resp_err   <= (state_d == ST_RESP) && (cause_d != CAUSE_NONE);
      resp_cause <= cause_d;
      resp_rdata <= rdata_d;
    end
  end

  // Capture the request and its formatted bus fields on accept; they stay stable through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo_q  <= 2'b00;
      funct3_q   <= 3'b000;
      write_q    <= 1'b0;
      wb_wr_en   <= 1'b0;
      wb_addr    <= '0;
      wb_wr_data <= 32'h0;
      wb_wr_sel  <= 4'h0;
    end else if (accept) begin
      addr_lo_q  <= req_addr[1:0];
      funct3_q   <= req_funct3;
      write_q    <= req_write;
      wb_wr_en   <= req_write;
      wb_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      wb_wr_data <= fmt_data;
      wb_wr_sel  <= fmt_sel;
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master: table of load/store vectors against a
// behavioural pipelined-Wishbone slave, scoreboarded responses, and hand-written
// sequences for fast ack, throughput, timeout, reset mid-cycle and stray acks.
module tb_lsu_wb_master;
  import lsu_pkg::*;

  localparam int AW = 10;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [1:0]    resp_cause;
  logic          wb_cyc, wb_stb, wb_wr_en;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wr_data;
  logic [3:0]    wb_wr_sel;
  logic          wb_ack = 1'b0;
  logic          wb_stall = 1'b0;
  logic [31:0]   wb_rd_data = 32'h0;

  logic [31:0]   ext_rd = 32'h0;
  logic [1:0]    ext_lo = 2'b0;
  logic [2:0]    ext_f3 = 3'b0;
  logic [31:0]   ext_res;

  always #5 clk = ~clk;

  lsu_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_cause(resp_cause),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
    .wb_wr_data(wb_wr_data), .wb_wr_sel(wb_wr_sel),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data)
  );

  lsu_load_extend u_ref_extend (
    .rd_data(ext_rd), .addr_lo(ext_lo), .funct3(ext_f3), .result(ext_res)
  );

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          stalls;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_cause;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  lo;
    logic [2:0]  f3;
    logic [31:0] res;
  } ext_vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;

  logic [31:0] slave_word = 32'h0;
  int          slave_stall_left = 0;
  logic        slave_ack_en = 1'b1;
  logic        slave_fast = 1'b0;
  logic        slave_pending = 1'b0;
  int          slave_spurious = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Pipelined Wishbone slave: optional stall cycles, ack one cycle after the
  // accepted strobe (or in the same cycle in fast mode), optionally never acks.
  task automatic slave_step();
    wb_ack     = 1'b0;
    wb_stall   = 1'b0;
    wb_rd_data = 32'hA5A5_A5A5;
    if (slave_spurious > 0) begin
      wb_ack = 1'b1;
      slave_spurious--;
    end else if (wb_cyc && wb_stb) begin
      if (slave_stall_left > 0) begin
        wb_stall = 1'b1;
        slave_stall_left--;
      end else if (slave_fast) begin
        wb_ack     = slave_ack_en;
        wb_rd_data = slave_word;
      end else begin
        slave_pending = 1'b1;
      end
    end else if (slave_pending) begin
      slave_pending = 1'b0;
      if (wb_cyc && slave_ack_en) begin
        wb_ack     = 1'b1;
        wb_rd_data = slave_word;
      end
    end
  endtask

  // Advance one cycle, update the slave and score any response.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    slave_step();
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("resp_cause", {30'h0, resp_cause}, {30'h0, e.cause});
        check("resp_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit push, input exp_t e);
    exp_t en;
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    if (push) begin
      en     = e;
      en.cyc = cycle + e.cyc;
      sb.push_back(en);
    end
    tick();
    req_valid = 1'b0;
    req_wdata = 32'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_missing", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    slave_stall_left = v.stalls;
    slave_word       = v.rword;
    slave_ack_en     = 1'b1;
    slave_fast       = 1'b0;
    e = '{v.exp_rdata, v.exp_err, v.exp_cause, v.lat};
    issue(v.write, v.f3, v.addr, v.wdata, 1'b1, e);
    if (v.exp_err) begin
      check($sformatf("v%0d_no_cyc", idx), {31'h0, wb_cyc}, 32'h0);
    end else begin
      check($sformatf("v%0d_cyc", idx), {31'h0, wb_cyc}, 32'h1);
      check($sformatf("v%0d_stb", idx), {31'h0, wb_stb}, 32'h1);
      check($sformatf("v%0d_addr", idx), 32'(wb_addr), v.exp_addr);
      check($sformatf("v%0d_sel", idx), {28'h0, wb_wr_sel}, {28'h0, v.exp_sel});
      check($sformatf("v%0d_wr_en", idx), {31'h0, wb_wr_en}, {31'h0, v.write});
      if (v.write) check($sformatf("v%0d_wdata", idx), wb_wr_data, v.exp_wdata);
      for (int s = 0; s < v.stalls; s++) begin
        tick();
        check($sformatf("v%0d_stall_stb", idx), {31'h0, wb_stb}, 32'h1);
        check($sformatf("v%0d_stall_addr", idx), 32'(wb_addr), v.exp_addr);
        check($sformatf("v%0d_stall_sel", idx), {28'h0, wb_wr_sel}, {28'h0, v.exp_sel});
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t     vecs[15];
    ext_vec_t evs[6];
    exp_t     e;

    vecs[0]  = '{1'b0, F3_W,  32'h10,        32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, CAUSE_NONE,     32'h010, 4'hF, 32'h0,        3};
    vecs[1]  = '{1'b0, F3_B,  32'h13,        32'h0,        32'h80FF0000, 0, 32'hFFFFFF80, 1'b0, CAUSE_NONE,     32'h010, 4'hF, 32'h0,        3};
    vecs[2]  = '{1'b0, F3_BU, 32'h13,        32'h0,        32'h80FF0000, 0, 32'h00000080, 1'b0, CAUSE_NONE,     32'h010, 4'hF, 32'h0,        3};
    vecs[3]  = '{1'b1, F3_H,  32'h22,        32'h1234ABCD, 32'hFFFFFFFF, 0, 32'h0,        1'b0, CAUSE_NONE,     32'h020, 4'hC, 32'hABCDABCD, 3};
    vecs[4]  = '{1'b1, F3_B,  32'h401,       32'h000000C3, 32'hFFFFFFFF, 0, 32'h0,        1'b0, CAUSE_NONE,     32'h000, 4'h2, 32'hC3C3C3C3, 3};
    vecs[5]  = '{1'b1, F3_W,  32'h3FC,       32'h11223344, 32'hFFFFFFFF, 0, 32'h0,        1'b0, CAUSE_NONE,     32'h3FC, 4'hF, 32'h11223344, 3};
    vecs[6]  = '{1'b0, F3_H,  32'h02,        32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 1'b0, CAUSE_NONE,     32'h000, 4'hF, 32'h0,        3};
    vecs[7]  = '{1'b0, F3_HU, 32'h02,        32'h0,        32'hBEEF0000, 3, 32'h0000BEEF, 1'b0, CAUSE_NONE,     32'h000, 4'hF, 32'h0,        6};
    vecs[8]  = '{1'b0, F3_B,  32'h02,        32'h0,        32'h007F0000, 1, 32'h0000007F, 1'b0, CAUSE_NONE,     32'h000, 4'hF, 32'h0,        4};
    vecs[9]  = '{1'b0, F3_W,  32'h06,        32'h0,        32'h0,        0, 32'h0,        1'b1, CAUSE_MISALIGN, 32'h0,   4'h0, 32'h0,        1};
    vecs[10] = '{1'b1, F3_H,  32'h05,        32'h55AA55AA, 32'h0,        0, 32'h0,        1'b1, CAUSE_MISALIGN, 32'h0,   4'h0, 32'h0,        1};
    vecs[11] = '{1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, CAUSE_ILLEGAL,  32'h0,   4'h0, 32'h0,        1};
    vecs[12] = '{1'b1, 3'b100, 32'h0,        32'h12345678, 32'h0,        0, 32'h0,        1'b1, CAUSE_ILLEGAL,  32'h0,   4'h0, 32'h0,        1};
    vecs[13] = '{1'b0, F3_H,  32'h01,        32'h0,        32'h0,        0, 32'h0,        1'b1, CAUSE_MISALIGN, 32'h0,   4'h0, 32'h0,        1};
    vecs[14] = '{1'b0, F3_W,  32'h10000404,  32'h0,        32'h5555AAAA, 0, 32'h5555AAAA, 1'b0, CAUSE_NONE,     32'h004, 4'hF, 32'h0,        3};

    evs[0] = '{32'h80FF0000, 2'd3, F3_B,  32'hFFFFFF80};
    evs[1] = '{32'h12345678, 2'd1, F3_BU, 32'h00000056};
    evs[2] = '{32'h12345678, 2'd0, F3_H,  32'h00005678};
    evs[3] = '{32'h87654321, 2'd2, F3_H,  32'hFFFF8765};
    evs[4] = '{32'h87654321, 2'd2, F3_HU, 32'h00008765};
    evs[5] = '{32'hCAFEBABE, 2'd0, F3_W,  32'hCAFEBABE};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_cause", {30'h0, resp_cause}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_wb_cyc", {31'h0, wb_cyc}, 32'h0);
    check("rst_wb_stb", {31'h0, wb_stb}, 32'h0);
    check("rst_wb_wr_en", {31'h0, wb_wr_en}, 32'h0);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_wr_data", wb_wr_data, 32'h0);
    check("rst_wb_wr_sel", {28'h0, wb_wr_sel}, 32'h0);
    rst = 1'b0;
    tick();

    // Standalone load formatter
    for (int i = 0; i < 6; i++) begin
      ext_rd = evs[i].rd;
      ext_lo = evs[i].lo;
      ext_f3 = evs[i].f3;
      #1;
      check($sformatf("extend_%0d", i), ext_res, evs[i].res);
    end

    // Table-driven transactions
    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Ack in the same cycle as the accepted strobe
    slave_fast = 1'b1;
    slave_word = 32'h0BADF00D;
    slave_ack_en = 1'b1;
    slave_stall_left = 0;
    e = '{32'h0BADF00D, 1'b0, CAUSE_NONE, 2};
    issue(1'b0, F3_W, 32'h40, 32'h0, 1'b1, e);
    drain();
    slave_fast = 1'b0;

    // req_ready low through REQ/WAIT/RESP, back high in cycle 4
    slave_word = 32'h01020304;
    e = '{32'h01020304, 1'b0, CAUSE_NONE, 3};
    issue(1'b0, F3_W, 32'h44, 32'h0, 1'b1, e);
    check("ready_c1", {31'h0, req_ready}, 32'h0);
    tick();
    check("ready_c2", {31'h0, req_ready}, 32'h0);
    tick();
    check("ready_c3", {31'h0, req_ready}, 32'h0);
    tick();
    check("ready_c4", {31'h0, req_ready}, 32'h1);
    drain();

    // Timeout: no ack, cyc held through WAIT then dropped with the response
    slave_ack_en = 1'b0;
    e = '{32'h0, 1'b1, CAUSE_TIMEOUT, TO + 2};
    issue(1'b0, F3_W, 32'h08, 32'h0, 1'b1, e);
    for (int c = 1; c < TO + 1; c++) tick();
    check("timeout_cyc_last_wait", {31'h0, wb_cyc}, 32'h1);
    tick();
    check("timeout_cyc_dropped", {31'h0, wb_cyc}, 32'h0);
    drain();

    // Reset while waiting for an ack: no response, bus released
    e = '{32'h0, 1'b0, CAUSE_NONE, 0};
    issue(1'b0, F3_W, 32'h0C, 32'h0, 1'b0, e);
    tick();
    check("rst_seq_in_wait", {31'h0, wb_cyc}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_seq_cyc", {31'h0, wb_cyc}, 32'h0);
    check("rst_seq_stb", {31'h0, wb_stb}, 32'h0);
    check("rst_seq_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_seq_ready", {31'h0, req_ready}, 32'h1);
    for (int c = 0; c < TO + 3; c++) tick();
    slave_ack_en = 1'b1;

    // Stray acks in IDLE are ignored
    slave_spurious = 2;
    tick();
    tick();
    tick();
    check("stray_ack_no_resp", {31'h0, resp_valid}, 32'h0);
    check("stray_ack_ready", {31'h0, req_ready}, 32'h1);
    run_vec(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_wb_master.md
# lsu_wb_master

Memory-stage load/store unit. Takes one load or store request per transaction from the pipeline and runs a single pipelined-Wishbone cycle against the data port of the unified main memory. It byte-aligns store data, generates byte selects, and sign- or zero-extends load data, returning one registered response per request. It also detects misaligned addresses, illegal funct3 encodings and bus timeouts.

## Interface
- ADDR_WIDTH, 10, Wishbone byte-address width; matches the memory's $clog2(MEMORY_BYTES)
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the cycle is aborted; must be ≥2

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  rs2 value (stores)
- resp_valid  out  1  one-cycle pulse, response for the accepted request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  response is an error
- resp_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout, 00 none
- wb_cyc, wb_stb, wb_wr_en  out  1 each  Wishbone control
- wb_addr  out  ADDR_WIDTH  req_addr[ADDR_WIDTH-1:2] with bits [1:0] forced to 0
- wb_wr_data  out  32  lane-replicated store data
- wb_wr_sel  out  4  byte selects
- wb_ack, wb_stall  in  1 each  slave handshake
- wb_rd_data  in  32  slave read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE.** On accept, latch addr[1:0], funct3, write and the formatted bus fields.
  - If misaligned or illegal, go to RESP with an error and issue no bus cycle.
  - Otherwise go to REQ.
- **REQ.** wb_cyc=wb_stb=1.
  - If !wb_stall: go to WAIT (stb=0, cyc=1).
  - If wb_ack arrives in the same cycle, go straight to RESP.
- **WAIT.** wb_cyc=1, wb_stb=0, timeout counter increments.
  - wb_ack: capture data, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: drop cyc, go to RESP with cause 11.
- **RESP.** resp_valid=1 for exactly one cycle, then IDLE.
- **Misaligned:** halfword with addr[0]=1; word with addr[1:0]≠0. Byte accesses are never misaligned.
- **Legal funct3:**
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - all others are illegal.
- **Store formatting:**
  - SB: sel = 0001<<addr[1:0], data = {4{wdata[7:0]}}
  - SH: sel = 0011<<addr[1:0], data = {2{wdata[15:0]}}
  - SW: sel = 1111, data = wdata
- **Loads:** wb_wr_sel=1111, wb_wr_en=0. The byte/halfword is selected by the latched addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Upper address bits above ADDR_WIDTH are ignored, so accesses wrap.
- wb_ack seen in IDLE or RESP is ignored.
- Dropping wb_cyc on timeout aborts the cycle; the slave discards it.

## Timing
- **Reset values:**
  - state=IDLE, req_ready=1
  - resp_valid=0, resp_err=0, resp_cause=00, resp_rdata=0
  - wb_cyc=wb_stb=wb_wr_en=0, wb_addr=0, wb_wr_data=0, wb_wr_sel=0
- **Zero-stall slave with next-cycle ack:**
  - accept at cycle 0
  - stb high in cycle 1
  - ack in cycle 2
  - resp_valid in cycle 3
  - next accept possible in cycle 4, since RESP is not IDLE
- **Error request:** accept at cycle 0, resp_valid in cycle 1, no wb_cyc.
- **Stalls:** stb stays high and the bus fields stay constant for each stalled cycle; latency grows by one per stall cycle.
- **Timeout:** resp_valid arrives TIMEOUT_CYCLES+2 cycles after accept.
- **rst during REQ/WAIT/RESP:** all outputs return to reset values on the next edge; a pending resp_valid is not emitted.
- All outputs are registered; no combinational path from wb_* to resp_*.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_TIMEOUT)
  - the state enum
- Sub-module lsu_load_extend: combinational lane select plus sign/zero extension (rd_data, addr[1:0], funct3 → 32-bit result), reused by the bench reference model.

## Test plan
- LW addr 0x10, slave returns 0xDEADBEEF, no stalls → wb_addr=0x10, sel=1111; resp_valid at cycle 3 with rdata 0xDEADBEEF, err=0.
- LB addr 0x13 with word 0x80FF_0000, and LBU addr 0x13 with the same word → 0xFFFFFF80 and 0x00000080.
- SH addr 0x22, wdata 0x1234ABCD → wb_wr_en=1, sel=1100, wb_wr_data=0xABCDABCD, addr 0x20; resp rdata 0.
- LW addr 0x06 and SH addr 0x05 → no wb_cyc; resp_valid cycle 1, err=1, cause=01. Load funct3=011 → cause=10.
- Slave holds wb_stall for 3 cycles then acks LHU addr 0x02 of 0xBEEF0000 → stb held 4 cycles, fields stable, rdata 0x0000BEEF at cycle 6.
- No ack with TIMEOUT_CYCLES=4 → cyc drops, cause=11 at cycle 6. Assert rst in WAIT of a second request → cyc=0 next cycle, no resp_valid, req_ready=1.
